// File: rtl/pulse_pkg.sv
// Shared types and width constants for the pulse sequencer slice.
package pulse_pkg;

    localparam int PER_W = 32;
    localparam int SEG_W = 16;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        NUT,
        NUT_GAP,
        P1,
        DEL,
        P2,
        ECHO_GAP,
        WAIT
    } state_t;

    // Timing words that shape the segment sequence of one period
    typedef struct packed {
        logic [CNT_W-1:0] nut_w;
        logic [SEG_W-1:0] nut_d;
        logic [SEG_W-1:0] p1wid;
        logic [SEG_W-1:0] del;
        logic [SEG_W-1:0] p2wid;
        logic [CNT_W-1:0] cp;
    } seq_t;

    // A segment: which state, how many cycles it lasts, pulse-2 repeats left
    typedef struct packed {
        state_t           st;
        logic [SEG_W:0]   len;
        logic [CNT_W-1:0] left;
    } seg_t;

    // Length in cycles of a segment; skipped segments report zero
    function automatic logic [SEG_W:0] seg_len(seq_t p, state_t st);
        logic [SEG_W:0] len;
        len = '0;
        case (st)
            NUT:      len = (SEG_W+1)'(p.nut_w);
            NUT_GAP:  len = (p.nut_w != '0) ? (SEG_W+1)'(p.nut_d) : '0;
            P1:       len = (SEG_W+1)'(p.p1wid);
            DEL:      len = (p.cp != '0) ? (SEG_W+1)'(p.del) : '0;
            P2:       len = (SEG_W+1)'(p.p2wid);
            ECHO_GAP: len = {p.del, 1'b0};
            default:  len = '0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/blank_stretch.sv
// Receiver blanking: inhib follows the RF gate and is held for p_bl cycles
// after every falling edge of the gate.
module blank_stretch
    import pulse_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse,   // gate level that appears on the next edge
    input  logic [CNT_W-1:0] p_bl,
    output logic             inhib
);

    logic             pulse_q;
    logic [CNT_W-1:0] stretch;
    logic [CNT_W-1:0] stretch_d;

    // Reload on a 1->0 gate transition, otherwise count down to zero
    always_comb begin
        stretch_d = '0;
        if (pulse_q && !pulse) begin
            stretch_d = p_bl;
        end else if (stretch != '0) begin
            stretch_d = stretch - CNT_W'(1);
        end
    end

    // Register the stretch counter and the blanking output alongside the gate
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= 1'b0;
            stretch <= '0;
            inhib   <= 1'b0;
        end else begin
            pulse_q <= pulse;
            stretch <= stretch_d;
            inhib   <= pulse || (stretch_d != '0);
        end
    end

endmodule

// File: rtl/pulse_sequencer.sv
// Period-driven pulse scheduler: nutation pulse, gap, pulse 1, delay and a
// CPMG train of pulse-2 repeats, restarted at every period boundary.
module pulse_sequencer
    import pulse_pkg::*;
#(
    parameter int MIN_PER = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PER_W-1:0] per,
    input  logic [CNT_W-1:0] nut_w,
    input  logic [SEG_W-1:0] nut_d,
    input  logic [SEG_W-1:0] p1wid,
    input  logic [SEG_W-1:0] del,
    input  logic [SEG_W-1:0] p2wid,
    input  logic [CNT_W-1:0] cp,
    input  logic             bl,
    input  logic [CNT_W-1:0] p_bl,
    output logic             sync_out,
    output logic             pulse,
    output logic             inhib,
    output logic             active,
    output logic [CNT_W-1:0] echo_idx
);

    localparam logic [PER_W-1:0] MIN_P = PER_W'(MIN_PER);

    seq_t             raw;
    seq_t             sh;
    logic [PER_W-1:0] per_sh;
    logic             bl_sh;
    logic [CNT_W-1:0] p_bl_sh;

    logic [PER_W-1:0] pcnt;
    logic [PER_W-1:0] per_eff;
    logic             start_pending;
    logic             boundary;

    state_t           state;
    logic [SEG_W:0]   seg_cnt;
    logic [CNT_W-1:0] left;
    seg_t             nxt;
    logic             pulse_d;
    logic [CNT_W-1:0] echo_d;

    // Walk forward from a segment to the first non-empty one (or WAIT).
    // With adv set the starting segment is left first; otherwise it is
    // itself a candidate. Zero-length segments therefore cost no cycles.
    function automatic seg_t walk(seq_t p, state_t st0, logic [CNT_W-1:0] left0, logic adv);
        state_t           st;
        logic [CNT_W-1:0] lf;
        logic             step;
        logic             done;
        seg_t             r;
        st   = st0;
        lf   = left0;
        step = adv;
        done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!done && !step && (st == WAIT || seg_len(p, st) != '0)) begin
                done = 1'b1;
            end
            if (!done) begin
                step = 1'b0;
                case (st)
                    NUT:      st = NUT_GAP;
                    NUT_GAP:  st = P1;
                    P1:       st = DEL;
                    DEL: begin
                        if (p.cp != '0) st = P2;
                        else            st = WAIT;
                        lf = p.cp;
                    end
                    P2: begin
                        // An empty pulse-2 width collapses the whole train
                        if (lf > CNT_W'(1) && p.p2wid != '0) begin
                            st = ECHO_GAP;
                            lf = lf - CNT_W'(1);
                        end else begin
                            st = WAIT;
                        end
                    end
                    ECHO_GAP: st = P2;
                    default:  st = WAIT;
                endcase
            end
        end
        r.st   = st;
        r.len  = seg_len(p, st);
        r.left = lf;
        return r;
    endfunction

    assign raw      = {nut_w, nut_d, p1wid, del, p2wid, cp};
    assign per_eff  = (per_sh < MIN_P) ? MIN_P : per_sh;
    // Last cycle of a period, or the first cycle out of reset
    assign boundary = start_pending || (pcnt == per_eff - PER_W'(1));

    // Next segment, next gate level and next echo count
    always_comb begin
        nxt     = '{st: state, len: seg_cnt, left: left};
        pulse_d = 1'b0;
        echo_d  = echo_idx;
        if (boundary) begin
            // New period starts from the live inputs being shadowed this cycle;
            // anything still running is abandoned here.
            nxt    = walk(raw, NUT, '0, 1'b0);
            echo_d = '0;
        end else begin
            if (state != WAIT) begin
                if (seg_cnt == (SEG_W+1)'(1)) begin
                    nxt = walk(sh, state, left, 1'b1);
                end else begin
                    nxt.len = seg_cnt - (SEG_W+1)'(1);
                end
            end
            if (state == P2 && seg_cnt == (SEG_W+1)'(1) && echo_idx < sh.cp) begin
                echo_d = echo_idx + CNT_W'(1);
            end
        end
        pulse_d = (nxt.st == NUT) || (nxt.st == P2) ||
                  (nxt.st == P1 && (boundary ? bl : bl_sh));
    end

    // Period counter, FSM state register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            start_pending <= 1'b1;
            pcnt          <= '0;
            state         <= WAIT;
            seg_cnt       <= '0;
            left          <= '0;
            sync_out      <= 1'b0;
            pulse         <= 1'b0;
            active        <= 1'b0;
            echo_idx      <= '0;
        end else begin
            start_pending <= 1'b0;
            pcnt          <= boundary ? '0 : pcnt + PER_W'(1);
            state         <= nxt.st;
            seg_cnt       <= nxt.len;
            left          <= nxt.left;
            sync_out      <= boundary;
            pulse         <= pulse_d;
            active        <= (nxt.st != WAIT);
            echo_idx      <= echo_d;
        end
    end

    // Shadow the programming words so UART updates only affect the next period
    always_ff @(posedge clk) begin
        if (boundary) begin
            sh      <= raw;
            per_sh  <= per;
            bl_sh   <= bl;
            p_bl_sh <= p_bl;
        end
    end

    blank_stretch u_blank (
        .clk   (clk),
        .rst   (rst),
        .pulse (pulse_d),
        .p_bl  (p_bl_sh),
        .inhib (inhib)
    );

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: directed scenarios with fixed expectations plus
// randomized programming, all compared each cycle against a timeline model.
module tb_pulse_sequencer;

    localparam int MIN_PER = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] per;
    logic [7:0]  nut_w;
    logic [15:0] nut_d;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [7:0]  cp;
    logic        bl;
    logic [7:0]  p_bl;
    logic        sync_out;
    logic        pulse;
    logic        inhib;
    logic        active;
    logic [7:0]  echo_idx;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pulse_sequencer #(.MIN_PER(MIN_PER)) dut (
        .clk      (clk),
        .rst      (rst),
        .per      (per),
        .nut_w    (nut_w),
        .nut_d    (nut_d),
        .p1wid    (p1wid),
        .del      (del),
        .p2wid    (p2wid),
        .cp       (cp),
        .bl       (bl),
        .p_bl     (p_bl),
        .sync_out (sync_out),
        .pulse    (pulse),
        .inhib    (inhib),
        .active   (active),
        .echo_idx (echo_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int per, nut_w, nut_d, p1wid, del, p2wid, cp, bl, p_bl;
    } prm_t;

    prm_t m_sh;
    int   m_off = 0;
    int   m_P = MIN_PER;
    bit   m_pend = 1'b1;
    int   m_stretch = 0;
    bit   m_prev = 1'b0;
    bit   e_sync, e_pulse, e_inhib, e_active;
    int   e_echo;

    function automatic prm_t cur_inputs();
        prm_t p;
        p.per = int'(per);     p.nut_w = int'(nut_w); p.nut_d = int'(nut_d);
        p.p1wid = int'(p1wid); p.del = int'(del);     p.p2wid = int'(p2wid);
        p.cp = int'(cp);       p.bl = int'(bl);       p.p_bl = int'(p_bl);
        return p;
    endfunction

    // Gate, activity and echo count at offset o of a period, from the timeline
    function automatic void eval(input prm_t p, input int o, output bit pu, output bit ac, output int ec);
        int a, p1e, s, last;
        a   = p.nut_w + ((p.nut_w != 0) ? p.nut_d : 0);
        p1e = a + p.p1wid;
        pu  = (o < p.nut_w) || (p.bl != 0 && o >= a && o < p1e);
        last = p1e;
        ec   = 0;
        for (int k = 0; k < p.cp; k++) begin
            s = p1e + p.del + k * (p.p2wid + 2 * p.del);
            if (o >= s && o < s + p.p2wid) pu = 1'b1;
            if (o >= s + p.p2wid) ec++;
            last = s + p.p2wid;
        end
        ac = (o < last);
    endfunction

    task automatic model_edge();
        int old_pbl;
        if (rst) begin
            m_off = 0; m_pend = 1'b1; m_stretch = 0; m_prev = 1'b0;
            e_sync = 0; e_pulse = 0; e_inhib = 0; e_active = 0; e_echo = 0;
            return;
        end
        old_pbl = m_sh.p_bl;
        if (m_pend || m_off == m_P - 1) begin
            m_sh   = cur_inputs();
            m_P    = (m_sh.per < MIN_PER) ? MIN_PER : m_sh.per;
            m_off  = 0;
            m_pend = 1'b0;
        end else begin
            m_off++;
        end
        eval(m_sh, m_off, e_pulse, e_active, e_echo);
        e_sync = (m_off == 0);
        if (m_prev && !e_pulse) m_stretch = old_pbl;
        else if (m_stretch > 0) m_stretch--;
        e_inhib = e_pulse || (m_stretch != 0);
        m_prev  = e_pulse;
    endtask

    // One clock: advance the model, then compare every output
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("sync_out", 32'(sync_out), 32'(e_sync));
        check("pulse", 32'(pulse), 32'(e_pulse));
        check("inhib", 32'(inhib), 32'(e_inhib));
        check("active", 32'(active), 32'(e_active));
        check("echo_idx", 32'(echo_idx), 32'(e_echo));
    endtask

    bit r_pulse[4096];
    bit r_inhib[4096];
    bit r_sync[4096];
    bit r_active[4096];
    int r_echo[4096];

    task automatic rec(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            r_pulse[base+i]  = pulse;
            r_inhib[base+i]  = inhib;
            r_sync[base+i]   = sync_out;
            r_active[base+i] = active;
            r_echo[base+i]   = int'(echo_idx);
        end
    endtask

    // Hold reset, confirm the idle values, release; next step lands on T0
    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        check("rst_sync", 32'(sync_out), 0);
        check("rst_pulse", 32'(pulse), 0);
        check("rst_inhib", 32'(inhib), 0);
        check("rst_active", 32'(active), 0);
        check("rst_echo", 32'(echo_idx), 0);
        rst = 1'b0;
    endtask

    task automatic set_prm(input int a_per, input int a_nw, input int a_nd, input int a_p1,
                           input int a_del, input int a_p2, input int a_cp, input int a_bl,
                           input int a_pbl);
        per = 32'(a_per);   nut_w = 8'(a_nw); nut_d = 16'(a_nd); p1wid = 16'(a_p1);
        del = 16'(a_del);   p2wid = 16'(a_p2); cp = 8'(a_cp);    bl = 1'(a_bl);
        p_bl = 8'(a_pbl);
    endtask

    task automatic rand_inputs();
        set_prm($urandom_range(0, 150),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0,
                $urandom_range(0, 8), $urandom_range(0, 10), $urandom_range(0, 10),
                $urandom_range(1, 6), $urandom_range(0, 4), $urandom_range(0, 1),
                $urandom_range(0, 8));
    endtask

    initial begin
        set_prm(2000, 0, 0, 30, 200, 60, 1, 1, 50);

        // Basic sequence over two periods
        do_reset();
        rec(0, 2400);
        check("basic_sync0", 32'(r_sync[0]), 1);
        check("basic_sync1", 32'(r_sync[1]), 0);
        check("basic_p1_rise", 32'(r_pulse[0]), 1);
        check("basic_p1_last", 32'(r_pulse[29]), 1);
        check("basic_p1_fall", 32'(r_pulse[30]), 0);
        check("basic_del", 32'(r_pulse[229]), 0);
        check("basic_p2_rise", 32'(r_pulse[230]), 1);
        check("basic_p2_last", 32'(r_pulse[289]), 1);
        check("basic_p2_fall", 32'(r_pulse[290]), 0);
        check("basic_inh79", 32'(r_inhib[79]), 1);
        check("basic_inh80", 32'(r_inhib[80]), 0);
        check("basic_inh339", 32'(r_inhib[339]), 1);
        check("basic_inh340", 32'(r_inhib[340]), 0);
        check("basic_echo", 32'(r_echo[290]), 1);
        check("basic_act289", 32'(r_active[289]), 1);
        check("basic_act290", 32'(r_active[290]), 0);
        check("basic_sync2000", 32'(r_sync[2000]), 1);
        check("basic_echo2000", 32'(r_echo[2000]), 0);
        check("basic_p2_2nd", 32'(r_pulse[2230]), 1);
        check("basic_inh2340", 32'(r_inhib[2340]), 0);

        // CPMG train
        set_prm(200, 0, 0, 4, 10, 5, 3, 1, 3);
        do_reset();
        rec(0, 200);
        check("cpmg_del", 32'(r_pulse[13]), 0);
        check("cpmg_p2a", 32'(r_pulse[14]), 1);
        check("cpmg_p2a_end", 32'(r_pulse[19]), 0);
        check("cpmg_gap", 32'(r_pulse[38]), 0);
        check("cpmg_p2b", 32'(r_pulse[39]), 1);
        check("cpmg_gap2", 32'(r_pulse[63]), 0);
        check("cpmg_p2c", 32'(r_pulse[64]), 1);
        check("cpmg_p2c_last", 32'(r_pulse[68]), 1);
        check("cpmg_p2c_end", 32'(r_pulse[69]), 0);
        check("cpmg_echo1", 32'(r_echo[19]), 1);
        check("cpmg_echo3", 32'(r_echo[69]), 3);
        check("cpmg_echo0", 32'(r_echo[0]), 0);

        // Nutation pulse with pulse 1 disabled
        set_prm(200, 8, 20, 30, 0, 5, 0, 0, 2);
        do_reset();
        rec(0, 200);
        check("nut_start", 32'(r_pulse[0]), 1);
        check("nut_last", 32'(r_pulse[7]), 1);
        check("nut_fall", 32'(r_pulse[8]), 0);
        check("nut_p1_off", 32'(r_pulse[28]), 0);
        check("nut_p1_off2", 32'(r_pulse[57]), 0);
        check("nut_slot_end", 32'(r_active[57]), 1);
        check("nut_slot_done", 32'(r_active[58]), 0);

        // Mid-period width update takes effect only from the next T0
        set_prm(200, 0, 0, 30, 0, 5, 0, 1, 2);
        do_reset();
        rec(0, 10);
        p1wid = 16'd40;
        rec(10, 300);
        check("upd_old_last", 32'(r_pulse[29]), 1);
        check("upd_old_fall", 32'(r_pulse[30]), 0);
        check("upd_new_sync", 32'(r_sync[200]), 1);
        check("upd_new_mid", 32'(r_pulse[239]), 1);
        check("upd_new_fall", 32'(r_pulse[240]), 0);

        // Period clamp
        set_prm(1, 0, 0, 0, 0, 5, 0, 0, 0);
        do_reset();
        rec(0, 6);
        check("clamp_s0", 32'(r_sync[0]), 1);
        check("clamp_s1", 32'(r_sync[1]), 0);
        check("clamp_s2", 32'(r_sync[2]), 1);
        check("clamp_s3", 32'(r_sync[3]), 0);
        check("clamp_s4", 32'(r_sync[4]), 1);

        // Overrun in the delay segment
        set_prm(100, 0, 0, 80, 50, 10, 2, 0, 4);
        do_reset();
        rec(0, 300);
        check("ovr_act99", 32'(r_active[99]), 1);
        check("ovr_sync100", 32'(r_sync[100]), 1);
        check("ovr_pulse100", 32'(r_pulse[100]), 0);
        check("ovr_sync200", 32'(r_sync[200]), 1);

        // Overrun with the gate high at the period end
        set_prm(100, 0, 0, 80, 10, 30, 2, 0, 4);
        do_reset();
        rec(0, 300);
        check("ovr2_p99", 32'(r_pulse[99]), 1);
        check("ovr2_p100", 32'(r_pulse[100]), 0);
        check("ovr2_inh100", 32'(r_inhib[100]), 1);
        check("ovr2_inh103", 32'(r_inhib[103]), 1);
        check("ovr2_inh104", 32'(r_inhib[104]), 0);
        check("ovr2_echo99", 32'(r_echo[99]), 0);
        check("ovr2_act100", 32'(r_active[100]), 1);
        check("ovr2_p190", 32'(r_pulse[190]), 1);

        // Reset in the middle of pulse 1
        set_prm(2000, 0, 0, 30, 200, 60, 1, 1, 50);
        do_reset();
        rec(0, 11);
        check("rmid_before", 32'(r_pulse[10]), 1);
        rst = 1'b1;
        step();
        check("rmid_pulse", 32'(pulse), 0);
        check("rmid_inhib", 32'(inhib), 0);
        rst = 1'b0;
        step();
        check("rmid_t0_sync", 32'(sync_out), 1);
        check("rmid_t0_pulse", 32'(pulse), 1);
        rec(0, 100);

        // Randomized programming, asynchronous updates and occasional resets
        rand_inputs();
        for (int c = 0; c < 9000; c++) begin
            if ($urandom_range(0, 39) == 0) rand_inputs();
            rst = ($urandom_range(0, 1999) == 0);
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Period-driven pulse scheduler that turns the programmed pulse parameters into a timed pulse train on every repetition period. Sequence order: optional nutation pulse, nutation gap, pulse 1, delay, then a CPMG train of pulse-2 repeats. It sits between the UART command block, which supplies the parameter words, and the RF switch and receiver-blanking pins. Parameters are shadowed at each period boundary, so an update over UART never corrupts a sequence in flight.

## Interface
- `MIN_PER`, default 2: minimum effective period in cycles; smaller `per` values are clamped up to this.
- `clk` in 1: system clock (~201 MHz, 4.975 ns/cycle).
- `rst` in 1: synchronous, active-high reset.
- `per` in 32: repetition period, in cycles.
- `nut_w` in 8: nutation pulse width in cycles; 0 means no nutation pulse.
- `nut_d` in 16: gap after the nutation pulse, in cycles.
- `p1wid` in 16: pulse 1 width, in cycles.
- `del` in 16: delay from pulse-1 end to the first pulse-2 start (tau).
- `p2wid` in 16: pulse 2 width, in cycles.
- `cp` in 8: number of pulse-2 repeats; 0 means no pulse 2.
- `bl` in 1: 1 = pulse 1 enabled; 0 = the pulse-1 slot elapses with `pulse` held low.
- `p_bl` in 8: blanking extension after each pulse falling edge, in cycles.
- `sync_out` out 1: one-cycle strobe in cycle T0 of every period.
- `pulse` out 1: RF gate.
- `inhib` out 1: receiver blanking.
- `active` out 1: high while the sequence is running (any state other than WAIT).
- `echo_idx` out 8: number of pulse-2 repeats completed in the current period.

## Operation
- Period counter `pcnt` (32 bit) runs 0 .. P−1, where P = max(per_shadow, MIN_PER).
- The cycle after `pcnt` = P−1 is T0 of the next period.
- In the cycle before T0, all inputs are latched into shadow registers. The first period after reset latches in the cycle `rst` is low after having been high.
- FSM states (shared enum): NUT, NUT_GAP, P1, DEL, P2, ECHO_GAP, WAIT.
- Segment lengths:
  - NUT = nut_w, `pulse`=1.
  - NUT_GAP = nut_d; skipped entirely if nut_w = 0.
  - P1 = p1wid, `pulse`=bl.
  - DEL = del.
  - P2 = p2wid, `pulse`=1, repeated cp times.
  - ECHO_GAP = 2·del (17-bit, no overflow) between consecutive P2 segments; no ECHO_GAP after the last P2.
  - WAIT lasts until the period ends.
  - If cp = 0, DEL and all P2 segments are skipped.
- A zero-length segment occupies zero cycles. Next-state logic selects the next non-empty segment in the same cycle.
- `echo_idx` increments on the last cycle of each P2 segment, saturates at cp, and clears at T0.
- Overrun: if the sequence is still running when `pcnt` = P−1, it is aborted. `pulse` goes low at T0 only if the next period does not start with a pulse. The new period then starts normally.
- `inhib` = `pulse` OR (stretch counter ≠ 0).
  - Stretch counter loads p_bl on every `pulse` 1→0 transition, otherwise decrements to 0.
  - It is not cleared by a period boundary.
- Inputs may change at any time; they affect only the next period's shadow.

## Timing
- All outputs are registered.
- Nutation timing: at T0, `sync_out`=1 and `pulse`=1 if nut_w > 0, so the nutation pulse occupies T0 .. T0+nut_w−1.
- Pulse-1 rising edge is at T0 + nut_w + (nut_w ? nut_d : 0).
- k-th pulse-2 start (k = 1..cp): P1end + del + (k−1)·(p2wid + 2·del), where P1end is the first cycle after P1.
- `inhib` falls exactly p_bl cycles after `pulse` falls; with p_bl = 0 it tracks `pulse`.
- Values during and after reset:
  - While `rst` is high: `sync_out`, `pulse`, `inhib`, `active` = 0, `echo_idx` = 0, pcnt = 0, stretch = 0.
  - The first T0 is the second cycle after `rst` falls.
- `rst` asserted mid-pulse forces `pulse` and `inhib` low on the next edge. There is no extension after reset.

## Structure
- Package `pulse_pkg`: FSM state enum; width constants PER_W = 32, SEG_W = 16, CNT_W = 8.
- Sub-module `blank_stretch` (inputs: `pulse`, `p_bl`; output: `inhib`).
- Period counter, shadow registers, FSM and the 17-bit segment down-counter live in the top-level module.

## Test plan
- Basic sequence: per=2000, nut_w=0, p1wid=30, del=200, p2wid=60, cp=1, bl=1, p_bl=50.
  - Required: `sync_out` at T0; `pulse` high T0..T0+29 and T0+230..T0+289.
  - Required: `inhib` falls at T0+80 and T0+340; the same pattern repeats every 2000 cycles.
- CPMG: cp=3, del=10, p2wid=5, p1wid=4, nut_w=0.
  - Required: P2 starts at T0+14, T0+39, T0+64; `echo_idx` reads 3 after T0+68.
- Nutation and disabled pulse 1: nut_w=8, nut_d=20, bl=0, p1wid=30.
  - Required: `pulse` high T0..T0+7, low through the P1 slot; P1 slot ends at T0+57.
- Mid-period update and period clamp:
  - Change p1wid 30→40 mid-period: old width holds for the current period, new width applies from the next T0.
  - per=1: the period behaves as 2 cycles.
- Overrun: per=100, p1wid=80, del=50, cp=2.
  - Required: sequence aborted at the period end, `pulse` low at the next T0 (nut_w=0), no stuck state.
- Reset at T0+10 of the basic case (mid pulse 1): `pulse`, `inhib` = 0 on the next edge; clean restart with T0 two cycles after `rst` falls.
